// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the single-bus datapath.
// Bus source/sink indices, memory FSM states, CON codes.
package bus_datapath_pkg;

  localparam int N_SRC = 9;
  localparam int N_DST = 11;

  localparam int SRC_RSEL  = 0;
  localparam int SRC_HI    = 1;
  localparam int SRC_LO    = 2;
  localparam int SRC_ZHI   = 3;
  localparam int SRC_ZLO   = 4;
  localparam int SRC_PC    = 5;
  localparam int SRC_MDR   = 6;
  localparam int SRC_IN    = 7;
  localparam int SRC_CSEXT = 8;

  localparam int DST_RSEL = 0;
  localparam int DST_HI   = 1;
  localparam int DST_LO   = 2;
  localparam int DST_Y    = 3;
  localparam int DST_Z    = 4;
  localparam int DST_PC   = 5;
  localparam int DST_IR   = 6;
  localparam int DST_MAR  = 7;
  localparam int DST_MDR  = 8;
  localparam int DST_CON  = 9;
  localparam int DST_OUT  = 10;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_REQ  = 1'b1
  } mem_state_e;

  localparam logic [1:0] CON_EQZ = 2'b00;
  localparam logic [1:0] CON_NEZ = 2'b01;
  localparam logic [1:0] CON_POS = 2'b10;
  localparam logic [1:0] CON_NEG = 2'b11;

endpackage

// File: rtl/bus_datapath_mc_mem_seq.sv
// Memory request sequencer: IDLE/REQ handshake with
// a no-ack timeout and sticky error reporting.
module mem_seq
  import bus_datapath_pkg::*;
#(
  parameter int MEM_TMO = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic mem_rd,
  input  logic mem_wr,
  input  logic mem_ack,
  output logic busy,
  output logic mem_req,
  output logic mem_we,
  output logic rd_done,
  output logic mem_err
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

  mem_state_e state;
  logic [7:0] cnt;
  logic       start;

  assign start   = mem_rd | mem_wr;
  assign mem_req = (state == MS_REQ);
  assign busy    = mem_req;
  assign rd_done = mem_req & mem_ack & ~mem_we;

  // Request state, write qualifier, timeout counter, sticky error
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= MS_IDLE;
      cnt     <= '0;
      mem_we  <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (start) begin
            state  <= MS_REQ;
            mem_we <= mem_wr;
            cnt    <= '0;
          end
        end
        MS_REQ: begin
          if (start)
            mem_err <= 1'b1;
          if (mem_ack) begin
            state <= MS_IDLE;
          end else if (cnt == TMO_LAST) begin
            state   <= MS_IDLE;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bus_datapath_mc.sv
// Single-bus multi-cycle datapath: register file, special
// registers, one-hot bus, CON logic and memory port.
module bus_datapath_mc
  import bus_datapath_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          NUM_REGS = 16,
  parameter int          ADDR_W   = 9,
  parameter int unsigned PC_INIT  = 0,
  parameter int          MEM_TMO  = 15
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [N_SRC-1:0]      src_sel,
  input  logic [N_DST-1:0]      dst_en,
  input  logic [2:0]            gr_sel,
  input  logic                  ba_out,
  input  logic                  inc_pc,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  output logic                  busy,
  output logic                  con_out,
  output logic [DATA_W-1:0]     ir,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [2*DATA_W-1:0]   alu_res,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     in_port,
  output logic [DATA_W-1:0]     out_port,
  output logic                  bus_err,
  output logic                  mem_err
);

  localparam int RI_W = $clog2(NUM_REGS);
  localparam logic [DATA_W-1:0] PC_RST = DATA_W'(PC_INIT);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   hi, lo, y, pc, mdr, in_reg;
  logic [2*DATA_W-1:0] z;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   bus, rsel_val, csext;
  logic [3:0]          field;
  logic [RI_W-1:0]     idx;
  logic                multi, con_next, rd_done;

  // Register field chosen by Gra > Grb > Grc, else R0
  always_comb begin
    field = 4'd0;
    priority case (1'b1)
      gr_sel[2]: field = ir[26:23];
      gr_sel[1]: field = ir[22:19];
      gr_sel[0]: field = ir[18:15];
      default:   field = 4'd0;
    endcase
  end

  assign idx      = field[RI_W-1:0];
  assign rsel_val = (ba_out && idx == '0) ? '0 : regs[idx];
  assign csext    = {{(DATA_W-19){ir[18]}}, ir[18:0]};
  assign multi    = |(src_sel & (src_sel - 9'd1));

  // Bus source mux: lowest set source index wins
  always_comb begin
    bus = '0;
    priority case (1'b1)
      src_sel[SRC_RSEL]:  bus = rsel_val;
      src_sel[SRC_HI]:    bus = hi;
      src_sel[SRC_LO]:    bus = lo;
      src_sel[SRC_ZHI]:   bus = z[2*DATA_W-1:DATA_W];
      src_sel[SRC_ZLO]:   bus = z[DATA_W-1:0];
      src_sel[SRC_PC]:    bus = pc;
      src_sel[SRC_MDR]:   bus = mdr;
      src_sel[SRC_IN]:    bus = in_reg;
      src_sel[SRC_CSEXT]: bus = csext;
      default:            bus = '0;
    endcase
  end

  // Branch condition evaluated on the current bus value
  always_comb begin
    con_next = 1'b0;
    case (ir[20:19])
      CON_EQZ: con_next = (bus == '0);
      CON_NEZ: con_next = (bus != '0);
      CON_POS: con_next = ~bus[DATA_W-1];
      CON_NEG: con_next = bus[DATA_W-1];
      default: con_next = 1'b0;
    endcase
  end

  assign alu_a     = y;
  assign alu_b     = bus;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

  // General register file
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (dst_en[DST_RSEL]) begin
      regs[idx] <= bus;
    end
  end

  // Special registers, I/O ports and sticky bus error
  always_ff @(posedge clk) begin
    if (clr) begin
      hi       <= '0;
      lo       <= '0;
      y        <= '0;
      z        <= '0;
      pc       <= PC_RST;
      ir       <= '0;
      in_reg   <= '0;
      out_port <= '0;
      con_out  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      in_reg <= in_port;
      if (dst_en[DST_HI])  hi       <= bus;
      if (dst_en[DST_LO])  lo       <= bus;
      if (dst_en[DST_Y])   y        <= bus;
      if (dst_en[DST_Z])   z        <= alu_res;
      if (dst_en[DST_IR])  ir       <= bus;
      if (dst_en[DST_OUT]) out_port <= bus;
      if (dst_en[DST_CON]) con_out  <= con_next;
      if (dst_en[DST_PC])
        pc <= bus;
      else if (inc_pc)
        pc <= pc + 1'b1;
      if (multi)
        bus_err <= 1'b1;
    end
  end

  // Memory address/data registers, frozen while a request is open
  always_ff @(posedge clk) begin
    if (clr) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (dst_en[DST_MAR] && !busy)
        mar <= bus[ADDR_W-1:0];
      if (rd_done)
        mdr <= mem_rdata;
      else if (dst_en[DST_MDR] && !busy)
        mdr <= bus;
    end
  end

  mem_seq #(
    .MEM_TMO(MEM_TMO)
  ) u_mem_seq (
    .clk     (clk),
    .clr     (clr),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .mem_ack (mem_ack),
    .busy    (busy),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .rd_done (rd_done),
    .mem_err (mem_err)
  );

endmodule

// File: tb/tb_bus_datapath_mc.sv
// Directed bench for bus_datapath_mc.
// Hand-computed expectations, one checking task.
module tb_bus_datapath_mc;
  import bus_datapath_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic [8:0]  src_sel;
  logic [10:0] dst_en;
  logic [2:0]  gr_sel;
  logic        ba_out, inc_pc, mem_rd, mem_wr;
  logic        busy, con_out;
  logic [31:0] ir, alu_a, alu_b;
  logic [63:0] alu_res;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] in_port, out_port;
  logic        bus_err, mem_err;

  int n_checks = 0;
  int n_errs   = 0;

  bus_datapath_mc #(
    .DATA_W(32), .NUM_REGS(16), .ADDR_W(9),
    .PC_INIT(4), .MEM_TMO(4)
  ) dut (
    .clk(clk), .clr(clr),
    .src_sel(src_sel), .dst_en(dst_en),
    .gr_sel(gr_sel), .ba_out(ba_out),
    .inc_pc(inc_pc), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .busy(busy),
    .con_out(con_out), .ir(ir),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .in_port(in_port),
    .out_port(out_port), .bus_err(bus_err),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [8:0] sb(input int i);
    return 9'd1 << i;
  endfunction

  function automatic logic [10:0] db(input int i);
    return 11'd1 << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_sel = '0; dst_en = '0; gr_sel = '0;
    ba_out = 0; inc_pc = 0;
    mem_rd = 0; mem_wr = 0;
  endtask

  task automatic xfer(input logic [8:0] s,
                      input logic [10:0] d);
    src_sel = s; dst_en = d;
    tick();
    src_sel = '0; dst_en = '0;
  endtask

  task automatic load_ir(input logic [31:0] v);
    in_port = v;
    tick();
    xfer(sb(SRC_IN), db(DST_IR));
  endtask

  task automatic peek(input string tag,
                      input logic [8:0] s,
                      input logic [31:0] exp);
    src_sel = s;
    #1;
    chk(tag, alu_b, exp);
    src_sel = '0;
  endtask

  task automatic pulse_clr();
    clr = 1;
    tick();
    clr = 0;
  endtask

  initial begin
    idle();
    clr = 1; alu_res = '0; mem_rdata = '0;
    mem_ack = 0; in_port = '0;
    tick(); tick();
    clr = 0;

    // reset state
    peek("pc_rst", sb(SRC_PC), 32'd4);
    peek("bus_none", 9'd0, 32'd0);
    chk("req_rst", mem_req, 0);
    chk("busy_rst", busy, 0);
    chk("buserr_rst", bus_err, 0);
    chk("memerr_rst", mem_err, 0);
    for (int i = 1; i < 16; i++) begin
      load_ir(32'(i) << 23);
      gr_sel = 3'b100;
      peek($sformatf("r%0d_rst", i),
           sb(SRC_RSEL), 32'd0);
      gr_sel = 3'b000;
    end

    // Csext into Y, Z halves, bus conflict
    load_ir(32'h0007_FFFD);
    src_sel = sb(SRC_CSEXT); dst_en = db(DST_Y);
    #1 chk("csext_bus", alu_b, 32'hFFFF_FFFD);
    tick(); idle();
    chk("y_csext", alu_a, 32'hFFFF_FFFD);
    alu_res = 64'h1111_2222_3333_4444;
    xfer(9'd0, db(DST_Z));
    peek("zhi", sb(SRC_ZHI), 32'h1111_2222);
    src_sel = sb(SRC_PC) | sb(SRC_ZLO);
    #1 chk("conflict_bus", alu_b, 32'h3333_4444);
    chk("buserr_pre", bus_err, 0);
    tick(); idle();
    chk("buserr_set", bus_err, 1);
    tick();
    chk("buserr_sticky", bus_err, 1);
    pulse_clr();
    chk("buserr_clr", bus_err, 0);

    // PC increment, load priority, wrap
    inc_pc = 1; tick(); inc_pc = 0;
    peek("pc_inc", sb(SRC_PC), 32'd5);
    in_port = 32'h100; tick();
    inc_pc = 1;
    xfer(sb(SRC_IN), db(DST_PC));
    inc_pc = 0;
    peek("pc_load_wins", sb(SRC_PC), 32'h100);
    in_port = 32'hFFFF_FFFF; tick();
    xfer(sb(SRC_IN), db(DST_PC));
    inc_pc = 1; tick(); inc_pc = 0;
    peek("pc_wrap", sb(SRC_PC), 32'd0);

    // register file via Gra/Grb, Z path, R0 and ba_out
    load_ir((32'd2 << 23) | (32'd3 << 19));
    in_port = 32'd5; tick();
    gr_sel = 3'b010;
    xfer(sb(SRC_IN), db(DST_RSEL));
    src_sel = sb(SRC_RSEL); dst_en = db(DST_Y);
    #1 chk("r3_read", alu_b, 32'd5);
    tick(); idle();
    chk("y_r3", alu_a, 32'd5);
    alu_res = 64'd2;
    xfer(9'd0, db(DST_Z));
    gr_sel = 3'b100;
    xfer(sb(SRC_ZLO), db(DST_RSEL));
    peek("r2_from_z", sb(SRC_RSEL), 32'd2);
    gr_sel = 3'b010;
    peek("r3_kept", sb(SRC_RSEL), 32'd5);
    gr_sel = 3'b000;
    in_port = 32'd7; tick();
    xfer(sb(SRC_IN), db(DST_RSEL));
    peek("r0_write", sb(SRC_RSEL), 32'd7);
    ba_out = 1;
    peek("r0_base0", sb(SRC_RSEL), 32'd0);
    ba_out = 0;

    // memory read, ack on third request cycle
    in_port = 32'h75; tick();
    xfer(sb(SRC_IN), db(DST_MAR));
    chk("mar", mem_addr, 9'h075);
    mem_rd = 1; tick(); mem_rd = 0;
    chk("rd_req1", mem_req, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_req2", mem_req, 1);
    tick();
    chk("rd_req3", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h0000_CAFE;
    tick();
    mem_ack = 0; mem_rdata = '0;
    chk("rd_req_drop", mem_req, 0);
    chk("rd_busy_drop", busy, 0);
    chk("rd_noerr", mem_err, 0);
    peek("mdr_rd", sb(SRC_MDR), 32'h0000_CAFE);

    // memory write with timeout, MAR frozen
    in_port = 32'h1234; tick();
    xfer(sb(SRC_IN), db(DST_MDR));
    mem_wr = 1; tick(); mem_wr = 0;
    chk("wr_req1", mem_req, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_wdata", mem_wdata, 32'h1234);
    in_port = 32'h0AA; tick();
    chk("wr_req2", mem_req, 1);
    xfer(sb(SRC_IN), db(DST_MAR) | db(DST_MDR));
    chk("wr_req3", mem_req, 1);
    chk("mar_frozen", mem_addr, 9'h075);
    chk("wdata_frozen", mem_wdata, 32'h1234);
    chk("tmo_noerr", mem_err, 0);
    tick();
    chk("wr_req4", mem_req, 1);
    tick();
    chk("tmo_drop", mem_req, 0);
    chk("tmo_err", mem_err, 1);
    peek("mdr_tmo", sb(SRC_MDR), 32'h1234);
    pulse_clr();
    chk("memerr_clr", mem_err, 0);

    // request while busy, then clr mid-transaction
    mem_rd = 1; tick(); mem_rd = 0;
    mem_wr = 1; tick(); mem_wr = 0;
    chk("busy_err", mem_err, 1);
    chk("busy_req", mem_req, 1);
    pulse_clr();
    chk("clr_req", mem_req, 0);
    chk("clr_busy", busy, 0);

    // CON conditions and output port
    load_ir(32'h0010_0000);
    in_port = 32'd0; tick();
    xfer(sb(SRC_IN), db(DST_CON));
    chk("con_pos_zero", con_out, 1);
    in_port = 32'h8000_0000; tick();
    xfer(sb(SRC_IN), db(DST_CON));
    chk("con_pos_neg", con_out, 0);
    load_ir(32'h0018_0000);
    in_port = 32'h8000_0000; tick();
    xfer(sb(SRC_IN), db(DST_CON));
    chk("con_neg", con_out, 1);
    load_ir(32'h0000_0000);
    in_port = 32'h0000_0003; tick();
    xfer(sb(SRC_IN), db(DST_CON));
    chk("con_eqz", con_out, 0);
    xfer(sb(SRC_IN), db(DST_OUT));
    chk("out_port", out_port, 32'h3);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
